// File: rtl/pmem_arbiter_if.sv
// Bus bundle between the cache-side requesters, the arbiter and physical memory.
// master = requesters plus memory model, slave = the arbiter.
interface pmem_arbiter_if #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
);
  logic [NUM_CH-1:0]        ch_read;
  logic [NUM_CH-1:0]        ch_write;
  logic [NUM_CH*ADDR_W-1:0] ch_address;
  logic [NUM_CH*LINE_W-1:0] ch_wdata;
  logic [NUM_CH-1:0]        ch_resp;
  logic [LINE_W-1:0]        ch_rdata;
  logic                     pmem_resp;
  logic [LINE_W-1:0]        pmem_rdata;
  logic                     pmem_read;
  logic                     pmem_write;
  logic [ADDR_W-1:0]        pmem_address;
  logic [LINE_W-1:0]        pmem_wdata;

  modport master (
    output ch_read, ch_write, ch_address, ch_wdata, pmem_resp, pmem_rdata,
    input  ch_resp, ch_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );

  modport slave (
    input  ch_read, ch_write, ch_address, ch_wdata, pmem_resp, pmem_rdata,
    output ch_resp, ch_rdata, pmem_read, pmem_write, pmem_address, pmem_wdata
  );
endinterface

// File: rtl/pmem_arbiter.sv
// Shares one physical memory port among NUM_CH line requesters, one transaction at a time.
// Define PMEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority (channel 0 highest).
module pmem_arbiter #(
  parameter int NUM_CH = 2,
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input logic            clk,
  input logic            rst_n,
  pmem_arbiter_if.slave  bus
);
  // state   | meaning
  // IDLE    | no transaction, arbitrate among pending requests
  // BUSY    | pmem_* outputs held until pmem_resp
  // RECOVER | dead cycle so the served channel can drop its request
  localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_BUSY    = 2'd1;
  localparam logic [1:0] ST_RECOVER = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [PTR_W-1:0]  gnt_q, gnt_d;
  logic [PTR_W-1:0]  win;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;
  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] resp;
  logic              any_req;

  assign req     = bus.ch_read | bus.ch_write;
  assign any_req = |req;

`ifdef PMEM_ARB_RR_EN
  logic [PTR_W-1:0] ptr_q, ptr_d;

  // Scan farthest-first so the channel closest to ptr overwrites the others.
  always_comb begin
    int idx;
    idx = 0;
    win = ptr_q;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      if (req[idx]) win = PTR_W'(idx);
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (state_q == ST_IDLE && any_req)
      ptr_d = (int'(win) == NUM_CH - 1) ? '0 : win + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end
`else
  always_comb begin
    win = '0;
    for (int i = NUM_CH - 1; i >= 0; i--)
      if (req[i]) win = PTR_W'(i);
  end
`endif

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (any_req) begin
          gnt_d   = win;
          wr_d    = bus.ch_write[win];
          rd_d    = bus.ch_read[win] & ~bus.ch_write[win];
          addr_d  = bus.ch_address[int'(win)*ADDR_W +: ADDR_W];
          wdata_d = bus.ch_wdata[int'(win)*LINE_W +: LINE_W];
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (bus.pmem_resp) begin
          rd_d    = 1'b0;
          wr_d    = 1'b0;
          state_d = ST_RECOVER;
        end
      end
      ST_RECOVER: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    resp = '0;
    for (int i = 0; i < NUM_CH; i++)
      resp[i] = (state_q == ST_BUSY) && bus.pmem_resp && (gnt_q == PTR_W'(i));
  end

  assign bus.ch_resp      = resp;
  assign bus.ch_rdata     = bus.pmem_rdata;
  assign bus.pmem_read    = rd_q;
  assign bus.pmem_write   = wr_q;
  assign bus.pmem_address = addr_q;
  assign bus.pmem_wdata   = wdata_q;
endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed testbench for pmem_arbiter with NUM_CH=2; expectations follow PMEM_ARB_RR_EN.
module tb_pmem_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  localparam logic [127:0] DATA_RD = 128'hDEAD_0123_4567_89AB_CDEF_0011_2233_BEEF;
  localparam logic [127:0] DATA_A  = 128'hAAAA_1111_AAAA_2222_AAAA_3333_AAAA_4444;
  localparam logic [127:0] DATA_B  = 128'hBBBB_5555_BBBB_6666_BBBB_7777_BBBB_8888;

  pmem_arbiter_if #(.NUM_CH(2), .ADDR_W(16), .LINE_W(128)) bus ();

  pmem_arbiter #(.NUM_CH(2), .ADDR_W(16), .LINE_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.ch_read    = '0;
    bus.ch_write   = '0;
    bus.ch_address = '0;
    bus.ch_wdata   = '0;
    bus.pmem_resp  = 1'b0;
    bus.pmem_rdata = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    bus.ch_read    = 2'b11;
    bus.ch_address = {16'h2000, 16'h1000};
    tick();
    n_checks++;
    if (bus.pmem_read !== 1'b0) begin n_fail++; $display("FAIL reset_read: got %b expected 0", bus.pmem_read); end
    n_checks++;
    if (bus.pmem_write !== 1'b0) begin n_fail++; $display("FAIL reset_write: got %b expected 0", bus.pmem_write); end
    n_checks++;
    if (bus.pmem_address !== 16'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0000", bus.pmem_address); end
    n_checks++;
    if (bus.pmem_wdata !== 128'h0) begin n_fail++; $display("FAIL reset_wdata: got %h expected 0", bus.pmem_wdata); end
    n_checks++;
    if (bus.ch_resp !== 2'b00) begin n_fail++; $display("FAIL reset_resp: got %b expected 00", bus.ch_resp); end
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.pmem_read !== 1'b1) begin n_fail++; $display("FAIL reset_release_read: got %b expected 1", bus.pmem_read); end
    n_checks++;
    if (bus.pmem_address !== 16'h1000) begin n_fail++; $display("FAIL reset_release_addr: got %h expected 1000", bus.pmem_address); end
    bus.ch_read   = 2'b00;
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_single_read();
    do_reset();
    bus.ch_read    = 2'b10;
    bus.ch_address = {16'h2040, 16'h0111};
    tick();
    n_checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h2040) begin
      n_fail++; $display("FAIL read_start: got rd=%b addr=%h expected rd=1 addr=2040", bus.pmem_read, bus.pmem_address);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      n_checks++;
      if (bus.pmem_read !== 1'b1 || bus.ch_resp !== 2'b00) begin
        n_fail++; $display("FAIL read_hold: got rd=%b resp=%b expected rd=1 resp=00", bus.pmem_read, bus.ch_resp);
      end
    end
    bus.pmem_resp  = 1'b1;
    bus.pmem_rdata = DATA_RD;
    #1;
    n_checks++;
    if (bus.ch_resp !== 2'b10) begin n_fail++; $display("FAIL read_resp: got %b expected 10", bus.ch_resp); end
    n_checks++;
    if (bus.ch_rdata !== DATA_RD) begin n_fail++; $display("FAIL read_data: got %h expected %h", bus.ch_rdata, DATA_RD); end
    tick();
    bus.pmem_resp = 1'b0;
    bus.ch_read   = 2'b00;
    #1;
    n_checks++;
    if (bus.ch_resp !== 2'b00 || bus.pmem_read !== 1'b0) begin
      n_fail++; $display("FAIL read_after: got resp=%b rd=%b expected resp=00 rd=0", bus.ch_resp, bus.pmem_read);
    end
    repeat (2) tick();
  endtask

  task automatic test_contention();
    int exp_g [4];
    int waited;
`ifdef PMEM_ARB_RR_EN
    exp_g = '{0, 1, 0, 1};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    do_reset();
    bus.ch_read    = 2'b11;
    bus.ch_address = {16'h2000, 16'h1000};
    for (int t = 0; t < 4; t++) begin
      waited = 0;
      do begin
        tick();
        waited++;
      end while (bus.pmem_read !== 1'b1 && waited < 10);
      n_checks++;
      if (bus.pmem_read !== 1'b1) begin
        n_fail++; $display("FAIL contention_timeout: txn %0d got no strobe after %0d cycles", t, waited);
      end else begin
        if (t > 0) begin
          n_checks++;
          if (waited !== 2) begin n_fail++; $display("FAIL contention_gap: txn %0d got %0d cycles expected 2", t, waited); end
        end
        n_checks++;
        if (bus.pmem_address !== (exp_g[t] == 1 ? 16'h2000 : 16'h1000)) begin
          n_fail++; $display("FAIL contention_addr: txn %0d got %h expected ch%0d", t, bus.pmem_address, exp_g[t]);
        end
        bus.pmem_resp = 1'b1;
        #1;
        n_checks++;
        if (bus.ch_resp !== (exp_g[t] == 1 ? 2'b10 : 2'b01)) begin
          n_fail++; $display("FAIL contention_grant: txn %0d got %b expected ch%0d", t, bus.ch_resp, exp_g[t]);
        end
        tick();
        bus.pmem_resp = 1'b0;
        n_checks++;
        if (bus.pmem_read !== 1'b0) begin n_fail++; $display("FAIL contention_drop: txn %0d got rd=%b expected 0", t, bus.pmem_read); end
      end
    end
    bus.ch_read = 2'b00;
    repeat (3) tick();
  endtask

  task automatic test_write_latch();
    do_reset();
    bus.ch_read    = 2'b01;
    bus.ch_write   = 2'b01;
    bus.ch_address = {16'h0, 16'h3000};
    bus.ch_wdata   = {128'h0, DATA_A};
    tick();
    bus.ch_wdata   = {128'h0, DATA_B};
    bus.ch_address = {16'h0, 16'h3333};
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (bus.pmem_write !== 1'b1 || bus.pmem_read !== 1'b0 || bus.pmem_wdata !== DATA_A || bus.pmem_address !== 16'h3000) begin
        n_fail++;
        $display("FAIL write_latch: cycle %0d got wr=%b rd=%b addr=%h wdata=%h expected wr=1 rd=0 addr=3000 wdata=%h",
                 i, bus.pmem_write, bus.pmem_read, bus.pmem_address, bus.pmem_wdata, DATA_A);
      end
      tick();
    end
    bus.pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (bus.ch_resp !== 2'b01) begin n_fail++; $display("FAIL write_resp: got %b expected 01", bus.ch_resp); end
    tick();
    bus.pmem_resp = 1'b0;
    bus.ch_read   = 2'b00;
    bus.ch_write  = 2'b00;
    n_checks++;
    if (bus.pmem_write !== 1'b0) begin n_fail++; $display("FAIL write_drop: got %b expected 0", bus.pmem_write); end
    repeat (2) tick();
  endtask

  task automatic test_withdraw_spurious();
    do_reset();
    bus.ch_read    = 2'b10;
    bus.ch_address = {16'h4400, 16'h0};
    tick();
    bus.ch_read = 2'b00;
    repeat (2) tick();
    n_checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h4400) begin
      n_fail++; $display("FAIL withdraw_hold: got rd=%b addr=%h expected rd=1 addr=4400", bus.pmem_read, bus.pmem_address);
    end
    bus.pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (bus.ch_resp !== 2'b10) begin n_fail++; $display("FAIL withdraw_resp: got %b expected 10", bus.ch_resp); end
    tick();
    bus.pmem_resp = 1'b0;
    tick();
    bus.pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (bus.ch_resp !== 2'b00) begin n_fail++; $display("FAIL spurious_resp: got %b expected 00", bus.ch_resp); end
    tick();
    n_checks++;
    if (bus.ch_resp !== 2'b00 || bus.pmem_read !== 1'b0) begin
      n_fail++; $display("FAIL spurious_idle: got resp=%b rd=%b expected resp=00 rd=0", bus.ch_resp, bus.pmem_read);
    end
    bus.pmem_resp = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic [15:0] exp_second;
`ifdef PMEM_ARB_RR_EN
    exp_second = 16'h2000;
`else
    exp_second = 16'h1000;
`endif
    do_reset();
    bus.ch_read    = 2'b11;
    bus.ch_address = {16'h2000, 16'h1000};
    tick();
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    repeat (2) tick();
    n_checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== exp_second) begin
      n_fail++; $display("FAIL midop_second: got rd=%b addr=%h expected rd=1 addr=%h", bus.pmem_read, bus.pmem_address, exp_second);
    end
    #2;
    rst_n = 1'b0;
    bus.pmem_resp = 1'b1;
    #1;
    n_checks++;
    if (bus.pmem_read !== 1'b0) begin n_fail++; $display("FAIL midop_async_drop: got %b expected 0", bus.pmem_read); end
    n_checks++;
    if (bus.ch_resp !== 2'b00) begin n_fail++; $display("FAIL midop_no_resp: got %b expected 00", bus.ch_resp); end
    bus.pmem_resp = 1'b0;
    rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.pmem_read !== 1'b1 || bus.pmem_address !== 16'h1000) begin
      n_fail++; $display("FAIL midop_regrant: got rd=%b addr=%h expected rd=1 addr=1000", bus.pmem_read, bus.pmem_address);
    end
    bus.ch_read   = 2'b00;
    bus.pmem_resp = 1'b1;
    tick();
    bus.pmem_resp = 1'b0;
    repeat (2) tick();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_contention();
    test_write_latch();
    test_withdraw_spurious();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
